// File: rtl/wr_linked_list.sv
// ----------------------------------------------------------------------------
// wr_linked_list
//
// Builds a singly linked list in memory from a stream of {D1,D0} word pairs.
// Each node takes three consecutive words: node+0 = D0, node+1 = D1 and
// node+2 = next_ptr. The first node lands at the base address sampled with
// start. Every later node address is popped from a free-pointer source. The
// last node's next_ptr is NULL_PTR.
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high. Ready never depends on valid. Once valid is raised, the producer
// holds it and its data until that edge.
//
// Ports
//   clk, rst_n         clock and asynchronous active-low reset
//   start, address     begin a list at 'address' (sampled only while idle)
//   in_vld/in_rdy      {D1,D0} pair handshake; in_data, in_last
//   fp_vld/fp_rdy      free-pointer pop handshake; fp_addr
//   wen/waddr/wdata    memory write port; the write is taken on the rising edge
//   busy               list construction in progress
//   done               one-cycle pulse after the terminator is written
// ----------------------------------------------------------------------------
module wr_linked_list #(
    parameter int                 AWIDTH   = 8,
    parameter int                 DWIDTH   = 8,
    parameter logic [DWIDTH-1:0]  NULL_PTR = {DWIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [AWIDTH-1:0]     address,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [2*DWIDTH-1:0]   in_data,
    input  logic                  in_last,
    input  logic                  fp_vld,
    output logic                  fp_rdy,
    input  logic [AWIDTH-1:0]     fp_addr,
    output logic                  wen,
    output logic [AWIDTH-1:0]     waddr,
    output logic [DWIDTH-1:0]     wdata,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_WR_D0  = 3'd2,
        S_WR_D1  = 3'd3,
        S_WR_PTR = 3'd4
    } state_t;

    // 'state' is the FSM register that assertion checkers can bind to.
    state_t                 state, state_nx;
    logic [AWIDTH-1:0]      cur, cur_nx;
    logic [2*DWIDTH-1:0]    data_q, data_nx;
    logic                   last_q, last_nx;
    logic                   done_q, done_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cur    <= '0;
            data_q <= '0;
            last_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cur    <= cur_nx;
            data_q <= data_nx;
            last_q <= last_nx;
            done_q <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        data_nx  = data_q;
        last_nx  = last_q;
        done_nx  = 1'b0;
        in_rdy   = 1'b0;
        fp_rdy   = 1'b0;
        wen      = 1'b0;
        waddr    = '0;
        wdata    = '0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    cur_nx   = address;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                in_rdy = 1'b1;
                if (in_vld) begin
                    data_nx  = in_data;
                    last_nx  = in_last;
                    state_nx = S_WR_D0;
                end
            end
            S_WR_D0: begin
                wen      = 1'b1;
                waddr    = cur;
                wdata    = data_q[DWIDTH-1:0];
                state_nx = S_WR_D1;
            end
            S_WR_D1: begin
                wen      = 1'b1;
                waddr    = cur + AWIDTH'(1);
                wdata    = data_q[2*DWIDTH-1:DWIDTH];
                state_nx = S_WR_PTR;
            end
            S_WR_PTR: begin
                if (last_q) begin
                    // Terminate the list; no pointer is consumed.
                    wen      = 1'b1;
                    waddr    = cur + AWIDTH'(2);
                    wdata    = NULL_PTR;
                    done_nx  = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    // Stall here until the free-pointer source has an address.
                    fp_rdy = 1'b1;
                    if (fp_vld) begin
                        wen      = 1'b1;
                        waddr    = cur + AWIDTH'(2);
                        wdata    = DWIDTH'(fp_addr);
                        cur_nx   = fp_addr;
                        state_nx = S_WAIT;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_wr_linked_list.sv
module tb_wr_linked_list;

    localparam int W = 17;  // {terminator, addr[7:0], data[7:0]}
    localparam int TO = 50; // cycle bound for every handshake wait

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  address;
    logic        in_vld;
    logic        in_rdy;
    logic [15:0] in_data;
    logic        in_last;
    logic        fp_vld;
    logic        fp_rdy;
    logic [7:0]  fp_addr;
    logic        wen;
    logic [7:0]  waddr;
    logic [7:0]  wdata;
    logic        busy;
    logic        done;

    wr_linked_list dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .address (address),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_data (in_data),
        .in_last (in_last),
        .fp_vld  (fp_vld),
        .fp_rdy  (fp_rdy),
        .fp_addr (fp_addr),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           errors    = 0;
    int           checks    = 0;
    int           pops      = 0;
    int           exp_pops  = 0;
    logic         done_due  = 1'b0;
    logic [15:0]  pair_tbl[0:7];
    logic [7:0]   fp_tbl[0:7];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Monitor: compares every memory write against the expected queue, counts
    // free-pointer pops and checks the done pulse one cycle after a terminator.
    always @(negedge clk) begin
        logic         pending;
        logic [W-1:0] e;
        pending  = done_due;
        done_due = 1'b0;
        if (rst_n) begin
            if (pending || done)
                check("done_pulse", {31'd0, done}, {31'd0, pending});
            if (fp_vld && fp_rdy)
                pops++;
            if (wen) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wen", {24'd0, waddr}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("waddr", {24'd0, waddr}, {24'd0, e[15:8]});
                    check("wdata", {24'd0, wdata}, {24'd0, e[7:0]});
                    done_due = e[16];
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [7:0] a);
        @(posedge clk); #1;
        start   = 1'b1;
        address = a;
        @(posedge clk); #1;
        start   = 1'b0;
        address = $urandom_range(0, 255);
    endtask

    // Sends one pair; returns at posedge+1 of the cycle after acceptance.
    task automatic send_pair(input logic [15:0] d, input logic last, input int gap);
        int n;
        repeat (gap) @(posedge clk);
        #1;
        in_vld  = 1'b1;
        in_data = d;
        in_last = last;
        n = 0;
        while (!in_rdy && n < TO) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= TO) check("in_rdy_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_vld  = 1'b0;
        in_data = $urandom_range(0, 65535);
        in_last = 1'b0;
    endtask

    // Supplies one free pointer after 'stall' cycles of fp_rdy with fp_vld low.
    task automatic give_fp(input logic [7:0] p, input int stall);
        int n;
        n = 0;
        while (!fp_rdy && n < TO) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= TO) check("fp_rdy_timeout", 32'd0, 32'd1);
        for (int k = 0; k < stall; k++) begin
            check("stall_fp_rdy", {31'd0, fp_rdy}, 32'd1);
            check("stall_wen", {31'd0, wen}, 32'd0);
            @(posedge clk); #1;
        end
        fp_vld  = 1'b1;
        fp_addr = p;
        exp_pops++;
        @(posedge clk); #1;
        fp_vld  = 1'b0;
        fp_addr = $urandom_range(0, 255);
    endtask

    // Builds a list of n nodes from pair_tbl/fp_tbl, pushing expected writes.
    task automatic send_list(input logic [7:0] base, input int n, input int gap, input int stall);
        logic [7:0] cur;
        logic       last;
        cur = base;
        do_start(base);
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            exp_q.push_back({1'b0, cur, pair_tbl[i][7:0]});
            exp_q.push_back({1'b0, 8'(cur + 8'd1), pair_tbl[i][15:8]});
            if (last)
                exp_q.push_back({1'b1, 8'(cur + 8'd2), 8'hFF});
            else
                exp_q.push_back({1'b0, 8'(cur + 8'd2), fp_tbl[i]});
            send_pair(pair_tbl[i], last, gap);
            if (!last) begin
                give_fp(fp_tbl[i], stall);
                cur = fp_tbl[i];
            end
        end
        repeat (6) @(posedge clk);
        #1;
        check("busy_after_list", {31'd0, busy}, 32'd0);
    endtask

    task automatic randomize_tables();
        for (int i = 0; i < 8; i++) begin
            pair_tbl[i] = 16'($urandom_range(0, 65535));
            fp_tbl[i]   = 8'($urandom_range(0, 255));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        address = 8'h00;
        in_vld  = 1'b0;
        in_data = 16'h0;
        in_last = 1'b0;
        fp_vld  = 1'b0;
        fp_addr = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wen", {31'd0, wen}, 32'd0);
        check("rst_in_rdy", {31'd0, in_rdy}, 32'd0);
        check("rst_fp_rdy", {31'd0, fp_rdy}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_waddr", {24'd0, waddr}, 32'd0);
        check("rst_wdata", {24'd0, wdata}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: two-node list at 0x10, second node at 0x40.
        pair_tbl[0] = 16'h1110; pair_tbl[1] = 16'h2120; fp_tbl[0] = 8'h40;
        send_list(8'h10, 2, 0, 0);

        // 2: free-pointer source stalls for 5 cycles.
        randomize_tables();
        send_list(8'h60, 2, 0, 5);

        // 3: 3-cycle gaps on in_vld between pairs.
        randomize_tables();
        send_list(8'h80, 4, 3, 1);

        // 4: address wrap on a single-node list.
        pair_tbl[0] = 16'hBBAA;
        send_list(8'hFE, 1, 0, 0);

        // 5: reset while writing D1, then a clean list at 0x20.
        do_start(8'h30);
        exp_q.push_back({1'b0, 8'h30, 8'h55});
        send_pair(16'h6655, 1'b0, 0);   // returns in the D0 write cycle
        @(posedge clk); #1;             // now in the D1 write cycle
        check("pre_rst_wen", {31'd0, wen}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wen", {31'd0, wen}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_in_rdy", {31'd0, in_rdy}, 32'd0);
        check("mid_rst_fp_rdy", {31'd0, fp_rdy}, 32'd0);
        check("mid_rst_q_empty", exp_q.size(), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        randomize_tables();
        send_list(8'h20, 3, 1, 2);

        // 6: start pulses while busy are ignored; in_vld in IDLE not accepted.
        randomize_tables();
        fork
            send_list(8'hA0, 3, 2, 1);
            begin
                repeat (4) @(posedge clk);
                #2;
                start   = 1'b1;
                address = 8'h33;
                repeat (6) @(posedge clk);
                #2;
                start   = 1'b0;
            end
        join
        in_vld  = 1'b1;
        in_data = 16'hDEAD;
        in_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("idle_in_rdy", {31'd0, in_rdy}, 32'd0);
            check("idle_busy", {31'd0, busy}, 32'd0);
        end
        in_vld  = 1'b0;
        in_last = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        check("exp_q_drained", exp_q.size(), 32'd0);
        check("fp_pop_count", pops, exp_pops);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
